// File: rtl/ll_walk_sched.sv
// Round-robin scheduler sharing one linked-list walker among N_REQ requesters.
// Owns the next-pointer table and streams one tagged pointer per beat.
module ll_walk_sched #(
  parameter int N     = 256,
  parameter int W_PTR = $clog2(N),
  parameter int N_REQ = 4,
  parameter int W_ID  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ*W_PTR-1:0] req_head,
  input  logic [N_REQ-1:0]       req_vld,
  output logic [N_REQ-1:0]       req_rdy,
  input  logic                   cfg_we,
  input  logic [W_PTR-1:0]       cfg_addr,
  input  logic [W_PTR-1:0]       cfg_next,
  output logic [W_PTR-1:0]       out_ptr,
  output logic [W_ID-1:0]        out_id,
  output logic                   out_last,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   err_loop,
  output logic [W_ID-1:0]        err_id,
  output logic                   busy
);

  typedef enum logic {S_IDLE, S_WALK} state_e;

  localparam int unsigned      NRU     = N_REQ;
  localparam logic [W_PTR-1:0] CNT_MAX = W_PTR'(N - 2);
  localparam logic [W_ID-1:0]  RR_INIT = W_ID'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [W_PTR-1:0] table_q [N];
  logic [W_PTR-1:0] cur_q, cur_d;
  logic [W_PTR-1:0] cnt_q, cnt_d;
  logic [W_ID-1:0]  id_q, id_d;
  logic [W_ID-1:0]  rr_q, rr_d;
  logic [W_ID-1:0]  err_id_q, err_id_d;
  logic             err_loop_q, err_loop_d;

  logic [W_PTR-1:0] heads [N_REQ];
  logic [W_PTR-1:0] nxt, win_head;
  logic [W_ID-1:0]  win, scan;
  logic             found, guard_hit, fin, hs, can_acc, accept;

  for (genvar g = 0; g < N_REQ; g++) begin : g_heads
    assign heads[g] = req_head[g*W_PTR +: W_PTR];
  end

  // Next-pointer table: reads are combinational, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) table_q[i] <= '0;
    end else if (cfg_we) begin
      table_q[cfg_addr] <= cfg_next;
    end
  end

  // Search starts one past the last winner and wraps modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int unsigned k = 1; k <= NRU; k++) begin
      scan = W_ID'((32'(rr_q) + k) % NRU);
      if (!found && req_vld[scan]) begin
        found = 1'b1;
        win   = scan;
      end
    end
  end

  assign win_head  = heads[win];
  assign nxt       = table_q[cur_q];
  assign guard_hit = (cnt_q == CNT_MAX);
  assign fin       = (nxt == '0) || guard_hit;
  assign hs        = (state_q == S_WALK) && out_rdy;
  assign can_acc   = (state_q == S_IDLE) || (hs && fin);
  assign accept    = can_acc && found;

  always_comb begin
    req_rdy = '0;
    if (accept && rst_n) req_rdy[win] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    rr_d       = rr_q;
    err_loop_d = 1'b0;
    err_id_d   = err_id_q;

    if (hs && !fin) begin
      cur_d = nxt;
      cnt_d = cnt_q + 1'b1;
    end

    if (hs && guard_hit && (nxt != '0)) begin
      err_loop_d = 1'b1;
      err_id_d   = id_q;
    end

    // A null head is consumed like any other grant but starts no walk.
    if (can_acc) begin
      state_d = S_IDLE;
      if (accept) begin
        rr_d = win;
        if (win_head != '0) begin
          cur_d   = win_head;
          id_d    = win;
          cnt_d   = '0;
          state_d = S_WALK;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      rr_q       <= RR_INIT;
      err_loop_q <= 1'b0;
      err_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      rr_q       <= rr_d;
      err_loop_q <= err_loop_d;
      err_id_q   <= err_id_d;
    end
  end

  assign out_vld  = (state_q == S_WALK);
  assign busy     = out_vld;
  assign out_ptr  = cur_q;
  assign out_id   = id_q;
  assign out_last = out_vld && fin;
  assign err_loop = err_loop_q;
  assign err_id   = err_id_q;

endmodule

// File: tb/tb_ll_walk_sched.sv
// Scoreboard bench for ll_walk_sched: beats and grants are predicted from a
// bench-side table model and round-robin pointer, then matched as they appear.
module tb_ll_walk_sched;

  localparam int N  = 256;
  localparam int NR = 4;

  typedef struct {
    logic [7:0] ptr;
    logic [1:0] id;
    logic       last;
    logic       err;
  } beat_t;

  typedef struct {
    int         id;
    logic [7:0] head;
  } gnt_t;

  logic        clk, rst_n;
  logic [31:0] req_head;
  logic [3:0]  req_vld, req_rdy;
  logic        cfg_we;
  logic [7:0]  cfg_addr, cfg_next;
  logic [7:0]  out_ptr;
  logic [1:0]  out_id, err_id;
  logic        out_last, out_vld, out_rdy, err_loop, busy;

  ll_walk_sched #(.N(N), .N_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_head(req_head), .req_vld(req_vld), .req_rdy(req_rdy),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next),
    .out_ptr(out_ptr), .out_id(out_id), .out_last(out_last),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .err_loop(err_loop), .err_id(err_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic [7:0] mtab [N];
  int         rr_m;
  beat_t      sb [$];
  gnt_t       gq [$];
  logic [7:0] hd [NR];
  logic [3:0] pend;
  int         err_due;
  int         err_id_exp;
  logic       lat_chk;
  logic       stall_arm;
  logic [7:0] stall_ptr;
  int         stall_left;
  int         busy_cyc, first_vld, last_vld;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) mtab[i] = 8'd0;
    rr_m = NR - 1;
    sb.delete();
    gq.delete();
    err_due = -10;
    lat_chk = 1'b0;
    stall_arm = 1'b0;
    stall_left = 0;
    pend = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_vld = '1;
    req_head = '0;
    cfg_we = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("rst_out_vld",  32'(out_vld), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_err_loop", 32'(err_loop), 32'd0);
    chk("rst_req_rdy",  32'(req_rdy), 32'd0);
    chk("rst_out_ptr",  32'(out_ptr), 32'd0);
    chk("rst_out_id",   32'(out_id), 32'd0);
    chk("rst_err_id",   32'(err_id), 32'd0);
    req_vld = '0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] nx);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_next = nx;
    mtab[a] = nx;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic push_walk(input int id, input logic [7:0] head);
    logic [7:0] p, nx;
    beat_t b;
    if (head == 8'd0) return;
    p = head;
    for (int c = 0; c < N; c++) begin
      nx = mtab[p];
      b.ptr  = p;
      b.id   = 2'(id);
      b.last = (nx == 8'd0) || (c == N - 2);
      b.err  = (nx != 8'd0) && (c == N - 2);
      sb.push_back(b);
      if (b.last) break;
      p = nx;
    end
  endtask

  // Requests in mask are raised together and held until granted.
  task automatic issue(input logic [3:0] mask);
    logic [3:0] rem;
    gnt_t g;
    rem = mask;
    while (rem != 4'd0) begin
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (rr_m + k) % NR;
        if (rem[idx]) begin
          g.id = idx;
          g.head = hd[idx];
          gq.push_back(g);
          push_walk(idx, hd[idx]);
          rem[idx] = 1'b0;
          rr_m = idx;
          break;
        end
      end
    end
    for (int i = 0; i < NR; i++)
      if (mask[i]) req_head[i*8 +: 8] = hd[i];
    req_vld = req_vld | mask;
    pend = pend | mask;
  endtask

  task automatic step();
    logic [3:0] granted;
    beat_t e;
    gnt_t g;
    int gi;
    @(negedge clk);
    if (stall_arm && out_vld && out_ptr == stall_ptr) begin
      out_rdy = 1'b0;
      stall_left = 3;
      stall_arm = 1'b0;
    end
    cyc++;
    if (lat_chk) chk("latency_vld", 32'(out_vld), 32'd1);
    lat_chk = 1'b0;
    granted = req_rdy;
    if (req_rdy != 4'd0) begin
      chk("rdy_onehot", 32'($countones(req_rdy)), 32'd1);
      gi = 0;
      for (int i = 0; i < NR; i++) if (req_rdy[i]) gi = i;
      if (gq.size() == 0) begin
        chk("grant_unexpected", 32'(req_rdy), 32'd0);
      end else begin
        g = gq.pop_front();
        chk("grant_id", 32'(gi), 32'(g.id));
        if (g.head != 8'd0) lat_chk = 1'b1;
      end
    end
    chk("busy", 32'(busy), 32'(out_vld));
    if (out_vld) begin
      busy_cyc++;
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
      if (sb.size() == 0) begin
        chk("beat_unexpected", 32'(out_ptr), 32'd0);
      end else begin
        e = sb[0];
        chk("out_ptr",  32'(out_ptr), 32'(e.ptr));
        chk("out_id",   32'(out_id), 32'(e.id));
        chk("out_last", 32'(out_last), 32'(e.last));
        if (out_rdy) begin
          void'(sb.pop_front());
          if (e.err) begin
            err_due = cyc + 1;
            err_id_exp = e.id;
          end
        end
      end
    end
    if (cyc == err_due) begin
      chk("err_loop_pulse", 32'(err_loop), 32'd1);
      chk("err_id", 32'(err_id), 32'(err_id_exp));
    end else begin
      chk("err_loop_quiet", 32'(err_loop), 32'd0);
    end
    @(posedge clk); #1;
    req_vld = req_vld & ~granted;
    pend = pend & ~granted;
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) out_rdy = 1'b1;
    end
  endtask

  task automatic run(input int budget, input int exp_busy);
    int n;
    n = 0;
    busy_cyc = 0;
    first_vld = -1;
    last_vld = -1;
    do begin
      step();
      n++;
    end while ((pend != 4'd0 || sb.size() != 0 || out_vld) && n < budget);
    chk("run_in_budget", 32'(n < budget), 32'd1);
    step();
    step();
    chk("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
    if (exp_busy > 0) chk("no_bubble_span", 32'(last_vld - first_vld + 1), 32'(exp_busy));
  endtask

  initial begin
    rst_n = 1'b1;
    req_vld = '0;
    req_head = '0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_next = '0;
    out_rdy = 1'b1;
    for (int i = 0; i < NR; i++) hd[i] = 8'd0;
    #2;
    do_reset();

    // single list 1->5->3->10
    wr(8'd1, 8'd5); wr(8'd5, 8'd3); wr(8'd3, 8'd10);
    hd[0] = 8'd1;
    issue(4'b0001);
    run(50, 4);

    // backpressure on node 5 for three cycles
    stall_arm = 1'b1;
    stall_ptr = 8'd5;
    issue(4'b0001);
    run(50, 7);

    // round-robin back-to-back, twice
    do_reset();
    wr(8'd7, 8'd15); wr(8'd15, 8'd8); wr(8'd2, 8'd4);
    hd[0] = 8'd7;
    hd[2] = 8'd2;
    issue(4'b0101);
    run(50, 5);
    issue(4'b0101);
    run(50, 5);

    // null head from req3, then order must continue from 3
    hd[3] = 8'd0;
    issue(4'b1000);
    run(50, 0);
    hd[0] = 8'd7;
    hd[3] = 8'd2;
    issue(4'b1001);
    run(50, 5);

    // loop guard: 7->15->7
    wr(8'd15, 8'd7);
    hd[1] = 8'd7;
    issue(4'b0010);
    run(600, 255);

    // reset in the middle of a walk
    do_reset();
    wr(8'd1, 8'd5); wr(8'd5, 8'd3); wr(8'd3, 8'd10);
    hd[0] = 8'd1;
    issue(4'b0001);
    step();
    step();
    chk("pre_reset_ptr", 32'(out_ptr), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_vld",  32'(out_vld), 32'd0);
    chk("midrst_busy",     32'(busy), 32'd0);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    chk("midrst_out_ptr",  32'(out_ptr), 32'd0);
    req_vld = '0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    hd[0] = 8'd1;
    issue(4'b0001);
    run(50, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
